// File: rtl/nfc_wb_slave.sv
// rtl/nfc_wb_slave.sv - Wishbone slave front-end of the NAND flash controller
// Page buffer plus ROW_ADDR/NFC_CMD/NFC_READY/NFC_ERROR registers and command launch.
module nfc_wb_slave #(
   parameter int WB_ADDR_WIDTH  = 16,
   parameter int WB_DATA_WIDTH  = 32,
   parameter int BUF_ADDR_WIDTH = 12,
   parameter int BUF_DATA_WIDTH = 8,
   parameter int ROW_ADDR_WIDTH = 17
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [WB_ADDR_WIDTH-1:0]  wb_addr,
   input  logic [WB_DATA_WIDTH-1:0]  wb_data_i_s,
   input  logic                      wb_we,
   input  logic                      wb_stb,
   input  logic                      wb_cyc,
   output logic                      wb_ack,
   output logic [WB_DATA_WIDTH-1:0]  wb_data_o_s,
   output logic                      eng_start,
   output logic [2:0]                eng_cmd,
   output logic [ROW_ADDR_WIDTH-1:0] eng_row,
   input  logic                      eng_done,
   input  logic [2:0]                eng_err,
   input  logic [BUF_ADDR_WIDTH-1:0] eng_buf_addr,
   input  logic                      eng_buf_we,
   input  logic [BUF_DATA_WIDTH-1:0] eng_buf_wdata,
   output logic [BUF_DATA_WIDTH-1:0] eng_buf_rdata
);

   localparam int BUF_DEPTH = 1 << BUF_ADDR_WIDTH;
   localparam logic [WB_ADDR_WIDTH-1:0] ROW_A   = WB_ADDR_WIDTH'(BUF_DEPTH);
   localparam logic [WB_ADDR_WIDTH-1:0] CMD_A   = WB_ADDR_WIDTH'(BUF_DEPTH + 1);
   localparam logic [WB_ADDR_WIDTH-1:0] READY_A = WB_ADDR_WIDTH'(BUF_DEPTH + 2);
   localparam logic [WB_ADDR_WIDTH-1:0] ERR_A   = WB_ADDR_WIDTH'(BUF_DEPTH + 3);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                      state_q, state_d;
   logic [BUF_DATA_WIDTH-1:0]   mem [BUF_DEPTH];
   logic [ROW_ADDR_WIDTH-1:0]   row_addr;
   logic [2:0]                  err_q;
   logic                        req, is_buf, wr_idle, cmd_valid, fire, done_hit;
   logic [BUF_ADDR_WIDTH-1:0]   buf_idx;
   logic [WB_DATA_WIDTH-1:0]    rdata;
   logic                        unused_data;

   assign req       = wb_stb & wb_cyc & ~wb_ack;
   assign is_buf    = (wb_addr >> BUF_ADDR_WIDTH) == '0;
   assign buf_idx   = wb_addr[BUF_ADDR_WIDTH-1:0];
   assign wr_idle   = req & wb_we & (state_q == IDLE);
   assign cmd_valid = (wb_data_i_s[2:0] != 3'd0) && (wb_data_i_s[2:0] <= 3'd5);
   assign unused_data = ^wb_data_i_s[WB_DATA_WIDTH-1:ROW_ADDR_WIDTH];

   always_comb begin
      state_d  = state_q;
      fire     = 1'b0;
      done_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && wb_we && wb_addr == CMD_A && cmd_valid) begin
               fire    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (eng_done) begin
               done_hit = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // READY is exactly "not tracking an operation", so it is derived from the state.
   always_comb begin
      rdata = '0;
      if (is_buf) begin
         rdata = WB_DATA_WIDTH'(mem[buf_idx]);
      end else begin
         case (wb_addr)
            ROW_A:   rdata = WB_DATA_WIDTH'(row_addr);
            READY_A: rdata = WB_DATA_WIDTH'(state_q == IDLE);
            ERR_A:   rdata = WB_DATA_WIDTH'(err_q);
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= IDLE;
         wb_ack        <= 1'b0;
         wb_data_o_s   <= '0;
         eng_start     <= 1'b0;
         eng_cmd       <= '0;
         eng_row       <= '0;
         eng_buf_rdata <= '0;
         row_addr      <= '0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         wb_ack        <= req;
         eng_start     <= fire;
         eng_buf_rdata <= mem[eng_buf_addr];
         if (req && !wb_we)
            wb_data_o_s <= rdata;
         if (fire) begin
            eng_cmd <= wb_data_i_s[2:0];
            eng_row <= row_addr;
            err_q   <= '0;
         end
         if (done_hit)
            err_q <= eng_err;
         if (wr_idle && wb_addr == ROW_A)
            row_addr <= wb_data_i_s[ROW_ADDR_WIDTH-1:0];
      end
   end

   // Engine write comes last so it wins a same-address collision.
   always_ff @(posedge clk_i) begin
      if (wr_idle && is_buf)
         mem[buf_idx] <= wb_data_i_s[BUF_DATA_WIDTH-1:0];
      if (eng_buf_we)
         mem[eng_buf_addr] <= eng_buf_wdata;
   end

endmodule
